sat_sub_pipe: RTL and testbench
===============================

Name: sat_sub_pipe

Overview:
- Pipelined signed saturating subtractor: result = in_a - in_b, clamped to the representable range on overflow, with an active-high per-result overflow flag.
- Valid/ready on both sides; 2-stage pipeline; sticky overflow status for the datapath controller.
- Counterpart to the combinational saturating adder. Used where a difference must be taken without wrap-around, e.g. error terms and de-accumulation.

Parameters:
- DATA_WIDTH, 16: width of signed operands and result.
- MAX_VALUE, 2**(DATA_WIDTH-1)-1: largest positive result; the most negative result is -(MAX_VALUE+1).
- OVF_CNT_WIDTH, 8: width of the overflow event counter. Only used with SAT_SUB_OVF_COUNT_EN.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts operands this cycle.
- in_a  input  DATA_WIDTH  signed minuend.
- in_b  input  DATA_WIDTH  signed subtrahend.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- result  output  DATA_WIDTH  signed saturated difference.
- overflow  output  1  high with out_valid when result was saturated.
- ovf_sticky  output  1  set by any overflow leaving stage 2; held until cleared.
- clr_ovf  input  1  single-cycle clear of ovf_sticky (and of ovf_count when the option is present).
- ovf_count  output  OVF_CNT_WIDTH  saturating overflow event count. Only present with SAT_SUB_OVF_COUNT_EN.

Behaviour:
- Reset (rst_n low, asynchronous): both stage valid bits, out_valid, result, overflow, ovf_sticky and ovf_count go to 0. Stage data registers go to 0.
- Reset mid-operation: in-flight operands are discarded with no output. in_ready is 1 in the first cycle after release.
- Stage 1 registers in_a, in_b and s1_valid.
- Stage 2 computes and registers result, overflow and out_valid (s2_valid).
- Advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. This is a combinational path from out_ready and is permitted.
- Transfer occurs when valid & ready are both high in the same cycle.
- Latency: 2 cycles from input transfer to out_valid when not stalled. Throughput: 1 result per cycle when out_ready is held high.
- Back-pressure: while out_ready is low with both stages full, in_ready = 0 and result/overflow/out_valid are held stable. No data is dropped or duplicated.
- Arithmetic: diff = a - b computed in DATA_WIDTH bits (two's complement wrap).
  - Overflow condition: sign(a) != sign(b) AND sign(diff) != sign(a).
  - On overflow: result = MAX_VALUE if a is non-negative, -(MAX_VALUE+1) if a is negative. Otherwise result = diff.
- Boundary: b = -(MAX_VALUE+1) is handled by the rule above with no special case.
  - a >= 0: overflow, result saturates to MAX_VALUE.
  - a = -1: result = MAX_VALUE, no overflow.
- ovf_sticky:
  - Set in the cycle a result with overflow = 1 transfers out (out_valid & out_ready & overflow).
  - clr_ovf clears it.
  - Clear and set in the same cycle: set wins (ovf_sticky = 1), so the event is not lost.
- overflow is only meaningful while out_valid = 1 and is 0 otherwise.

Optional Feature:
- Macro SAT_SUB_OVF_COUNT_EN.
- Defined:
  - ovf_count increments by 1 on each overflowing output transfer and saturates at all-ones (no wrap).
  - clr_ovf forces it to 0.
  - Clear and increment in the same cycle: ovf_count = 1.
- Not defined: the ovf_count port and counter logic are absent. All other behaviour is identical.

Test Plan (DATA_WIDTH = 16):
- Basic: a = 100, b = 30, out_ready = 1 -> result = 70, overflow = 0, out_valid exactly 2 cycles after the transfer.
- Positive saturation: a = 32767, b = -1 -> result = 32767, overflow = 1, ovf_sticky = 1 after the output transfer. Repeat with a = 0, b = -32768 -> result = 32767, overflow = 1.
- Negative saturation and edge: a = -32768, b = 1 -> result = -32768, overflow = 1. a = -1, b = -32768 -> result = 32767, overflow = 0.
- Back-pressure: stream 5 pairs (1,0)...(5,0) with out_ready = 0 for 4 cycles.
  - in_ready drops after 2 accepted.
  - result holds 1 while stalled.
  - After release, outputs arrive in order as 1, 2, 3, 4, 5, with no loss or duplication.
- Reset mid-stream: assert rst_n = 0 with both stages full -> out_valid = 0, ovf_sticky = 0 immediately (asynchronous). No stale result appears after release.
- With SAT_SUB_OVF_COUNT_EN:
  - 300 consecutive overflowing pairs with OVF_CNT_WIDTH = 8 -> ovf_count = 255, held there.
  - clr_ovf in the same cycle as an overflowing transfer -> ovf_count = 1, ovf_sticky = 1.

Source files
------------

// File: rtl/sat_sub_pipe.sv
// Two-stage signed saturating subtractor (result = a - b, clamped) with a sticky overflow flag.
// Latency: 2 cycles from input transfer to out_valid; 1 result/cycle when out_ready is held high.
// Backpressure: in_ready = s1_adv (combinational from out_ready); SAT_SUB_OVF_COUNT_EN adds ovf_count.
module sat_sub_pipe #(
    parameter int DATA_WIDTH    = 16,
    parameter int MAX_VALUE     = 2**(DATA_WIDTH-1)-1,
    parameter int OVF_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_a,
    input  logic [DATA_WIDTH-1:0]    in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    result,
    output logic                     overflow,
    output logic                     ovf_sticky,
    input  logic                     clr_ovf
`ifdef SAT_SUB_OVF_COUNT_EN
    ,
    output logic [OVF_CNT_WIDTH-1:0] ovf_count
`endif
);

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(MAX_VALUE);
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
    localparam int                    MSB     = DATA_WIDTH - 1;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_a;
    logic [DATA_WIDTH-1:0] s1_b;
    logic                  s1_adv;
    logic                  s2_adv;
    logic [DATA_WIDTH-1:0] diff;
    logic                  ovf_c;
    logic [DATA_WIDTH-1:0] res_c;
    logic                  ovf_evt;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Overflow is only possible when operand signs differ and the wrapped difference flips sign.
    always_comb begin
        diff  = s1_a - s1_b;
        ovf_c = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
        res_c = diff;
        if (ovf_c) begin
            res_c = s1_a[MSB] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a <= in_a;
                s1_b <= in_b;
            end
        end
    end

    // A bubble moving into stage 2 clears overflow so it never shows without out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            result    <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            overflow  <= s1_valid && ovf_c;
            if (s1_valid) begin
                result <= res_c;
            end
        end
    end

    assign ovf_evt = out_valid && out_ready && overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (ovf_evt) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end

`ifdef SAT_SUB_OVF_COUNT_EN
    // A clear coinciding with an event restarts the count at 1 so the event is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (clr_ovf) begin
            ovf_count <= ovf_evt ? OVF_CNT_WIDTH'(1) : '0;
        end else if (ovf_evt && (ovf_count != {OVF_CNT_WIDTH{1'b1}})) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sat_sub_pipe.sv
// Randomized and directed bench for sat_sub_pipe against an integer-arithmetic reference model.
module tb_sat_sub_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        ovf_sticky;
    logic        clr_ovf;
`ifdef SAT_SUB_OVF_COUNT_EN
    logic [7:0]  ovf_count;
`endif

    int checks = 0;
    int errors = 0;

    logic        in_fire;
    logic        out_fire;
    logic [15:0] last_res;
    logic        last_ovf;

    sat_sub_pipe #(
        .DATA_WIDTH   (16),
        .MAX_VALUE    (32767),
        .OVF_CNT_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .ovf_sticky(ovf_sticky),
        .clr_ovf   (clr_ovf)
`ifdef SAT_SUB_OVF_COUNT_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference: exact integer difference, then clamp to the 16-bit signed range.
    function automatic void ref_sub(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic o);
        int ia;
        int ib;
        int d;
        ia = $signed(a);
        ib = $signed(b);
        d  = ia - ib;
        if (d > 32767) begin
            r = 16'h7FFF;
            o = 1'b1;
        end else if (d < -32768) begin
            r = 16'h8000;
            o = 1'b1;
        end else begin
            r = d[15:0];
            o = 1'b0;
        end
    endfunction

    // Inputs are set at a falling edge; handshakes are sampled just before the rising edge.
    task automatic step();
        #1;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (out_fire) begin
            last_res = result;
            last_ovf = overflow;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (result !== 16'h0000 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_result: got %h/%b expected 0000/0", result, overflow);
        end
        checks++;
        if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", ovf_sticky); end
`ifdef SAT_SUB_OVF_COUNT_EN
        checks++;
        if (ovf_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", ovf_count); end
`endif
    endtask

    task automatic test_basic();
        in_a = 16'd100; in_b = 16'd30; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (in_fire !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b expected 1", in_fire); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency1: out_valid got %b expected 0", out_valid); end
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 16'd70 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got v=%b r=%0d o=%b expected v=1 r=70 o=0", out_valid, result, overflow);
        end
        step();
    endtask

    task automatic test_saturation();
        logic [15:0] ta[4];
        logic [15:0] tb[4];
        logic [15:0] tr[4];
        logic        to[4];
        int          n;
        ta = '{16'h7FFF, 16'h0000, 16'h8000, 16'hFFFF};
        tb = '{16'hFFFF, 16'h8000, 16'h0001, 16'h8000};
        tr = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF};
        to = '{1'b1, 1'b1, 1'b1, 1'b0};
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b0;
            in_a = ta[i]; in_b = tb[i]; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 8) begin step(); n++; end
            checks++;
            if (out_valid !== 1'b1 || result !== tr[i] || overflow !== to[i]) begin
                errors++;
                $display("FAIL sat_case%0d: got v=%b r=%h o=%b expected v=1 r=%h o=%b",
                         i, out_valid, result, overflow, tr[i], to[i]);
            end
            out_ready = 1'b1;
            step();
            if (i == 0) begin
                checks++;
                if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b expected 1", ovf_sticky); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int          idx;
        logic [15:0] got[$];
        do_reset();
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (idx < 5); in_a = 16'(idx + 1); in_b = 16'd0;
            step();
            if (in_fire) idx++;
            if (out_valid) begin
                checks++;
                if (result !== 16'd1) begin errors++; $display("FAIL bp_hold: got %0d expected 1", result); end
            end
        end
        in_a = 16'(idx + 1);
        checks++;
        if (idx !== 2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accepted: got %0d in_ready=%b expected 2 in_ready=0", idx, in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 30 && got.size() < 5; c++) begin
            in_valid = (idx < 5); in_a = 16'(idx + 1);
            step();
            if (in_fire) idx++;
            if (out_fire) got.push_back(last_res);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (out_fire) got.push_back(last_res);
        end
        checks++;
        if (got.size() != 5) begin errors++; $display("FAIL bp_count: got %0d outputs expected 5", got.size()); end
        for (int k = 0; k < 5 && k < got.size(); k++) begin
            checks++;
            if (got[k] !== 16'(k + 1)) begin errors++; $display("FAIL bp_order%0d: got %0d expected %0d", k, got[k], k + 1); end
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        in_a = 16'h7FFF; in_b = 16'hFFFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'd9; in_b = 16'd4;
        for (int c = 0; c < 3; c++) step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || ovf_sticky !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: got v=%b rdy=%b st=%b expected 1 0 1", out_valid, in_ready, ovf_sticky);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ovf_sticky !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async: got v=%b st=%b o=%b expected 0 0 0", out_valid, ovf_sticky, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", in_ready); end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (out_fire) begin errors++; $display("FAIL rst_mid_stale: got output %h expected none", last_res); end
        end
    endtask

    task automatic test_random();
        logic [15:0] q_r[$];
        logic        q_o[$];
        logic [15:0] er;
        logic        eo;
        logic        sticky_m;
        int          cnt_m;
        do_reset();
        sticky_m = 1'b0;
        cnt_m    = 0;
        for (int c = 0; c < 1600; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_a      = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 16'h7FFF : 16'h8000) : 16'($urandom);
            in_b      = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 16'h7FFF : 16'h8000) : 16'($urandom);
            out_ready = (c > 1580) || ($urandom_range(2) != 0);
            clr_ovf   = ($urandom_range(15) == 0);
            if (c > 1570) in_valid = 1'b0;
            step();
            if (in_fire) begin
                ref_sub(in_a, in_b, er, eo);
                q_r.push_back(er);
                q_o.push_back(eo);
            end
            if (out_fire) begin
                checks++;
                if (q_r.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious: got output %h expected none", last_res);
                end else begin
                    er = q_r.pop_front();
                    eo = q_o.pop_front();
                    if (last_res !== er || last_ovf !== eo) begin
                        errors++; $display("FAIL rnd_result: got %h/%b expected %h/%b", last_res, last_ovf, er, eo);
                    end
                end
            end
            if (out_fire && last_ovf) begin
                sticky_m = 1'b1;
                cnt_m    = clr_ovf ? 1 : ((cnt_m < 255) ? cnt_m + 1 : 255);
            end else if (clr_ovf) begin
                sticky_m = 1'b0;
                cnt_m    = 0;
            end
            checks++;
            if (ovf_sticky !== sticky_m) begin errors++; $display("FAIL rnd_sticky: got %b expected %b", ovf_sticky, sticky_m); end
`ifdef SAT_SUB_OVF_COUNT_EN
            checks++;
            if (ovf_count !== 8'(cnt_m)) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", ovf_count, cnt_m); end
`endif
            if (!out_valid) begin
                checks++;
                if (overflow !== 1'b0) begin errors++; $display("FAIL rnd_ovf_idle: got %b expected 0", overflow); end
            end
        end
        clr_ovf = 1'b0;
        checks++;
        if (q_r.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d pending expected 0", q_r.size()); end
    endtask

    task automatic test_clear_collision();
        int n;
        do_reset();
        out_ready = 1'b1;
        in_a = 16'h8000; in_b = 16'h0001; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) step();
        out_ready = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 8) begin step(); n++; end
        checks++;
        if (out_valid !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL clr_pre: got v=%b o=%b expected 1 1", out_valid, overflow);
        end
        clr_ovf = 1'b1; out_ready = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++;
        if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL clr_set_wins: got %b expected 1", ovf_sticky); end
`ifdef SAT_SUB_OVF_COUNT_EN
        checks++;
        if (ovf_count !== 8'd1) begin errors++; $display("FAIL clr_count: got %0d expected 1", ovf_count); end
`endif
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++;
        if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL clr_plain: got %b expected 0", ovf_sticky); end
    endtask

`ifdef SAT_SUB_OVF_COUNT_EN
    task automatic test_ovf_count();
        int sent;
        do_reset();
        out_ready = 1'b1;
        in_a = 16'h7FFF; in_b = 16'hFFFF;
        sent = 0;
        for (int c = 0; c < 400 && sent < 300; c++) begin
            in_valid = 1'b1;
            step();
            if (in_fire) sent++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (sent != 300 || ovf_count !== 8'd255) begin
            errors++; $display("FAIL cnt_sat: got %0d after %0d pairs expected 255 after 300", ovf_count, sent);
        end
        for (int c = 0; c < 3; c++) step();
        checks++;
        if (ovf_count !== 8'd255) begin errors++; $display("FAIL cnt_hold: got %0d expected 255", ovf_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        test_clear_collision();
`ifdef SAT_SUB_OVF_COUNT_EN
        test_ovf_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
